// File: rtl/matmul_result_streamer.sv
// -----------------------------------------------------------------------------
// matmul_result_streamer
// Downstream stage of the 3x3 matmul core. It captures one frame of N_ELEM
// result words, arriving row-major C00..C22. It then replays the frame as
// 2*N_ELEM bytes on a narrow output port, low byte first for each word. The
// pace of the output is set by an off-chip read-request pin: each rising edge
// of rd_req moves the output on by one byte.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   clear        synchronous abort: back to IDLE, pointers and frame_err cleared
//   in_valid     result word valid
//   in_data      result word
//   in_last      marks the final word of a frame
//   in_ready     a word is accepted when in_valid & in_ready (low only in DRAIN)
//   rd_req       asynchronous pin; each rising edge advances one byte in DRAIN
//   out_byte     current byte (0 in IDLE/FILL, 8'hFF in DONE)
//   out_valid    out_byte holds a frame byte
//   out_last     out_byte is the final byte of the frame
//   done         frame fully read out
//   frame_err    sticky framing error (in_last misplaced or missing)
// -----------------------------------------------------------------------------
module matmul_result_streamer #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8,
    parameter int N_ELEM = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              rd_req,
    output logic [OUT_W-1:0]  out_byte,
    output logic              out_valid,
    output logic              out_last,
    output logic              done,
    output logic              frame_err
);

    localparam int N_BYTES = 2 * N_ELEM;
    localparam int RD_W    = $clog2(N_BYTES);
    localparam int WR_W    = $clog2(N_ELEM);

    localparam logic [RD_W-1:0] RD_LAST = RD_W'(N_BYTES - 1);
    localparam logic [WR_W-1:0] WR_LAST = WR_W'(N_ELEM - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [WR_W-1:0]    wr_ptr_r, wr_ptr_s;
    logic [RD_W-1:0]    rd_ptr_r, rd_ptr_s;
    logic               frame_err_r, frame_err_s;
    logic [DATA_W-1:0]  mem_r [N_ELEM];
    logic               wr_en_s;
    logic [WR_W-1:0]    wr_addr_s;
    logic               accept_s;
    logic               sync1_r, sync2_r, sync3_r;
    logic               rd_edge_s;
    logic [OUT_W-1:0]   out_byte_r, out_byte_s;
    logic               out_valid_r, out_valid_s;
    logic               out_last_r, out_last_s;
    logic               done_r, done_s;

    // Picks the high or low half of a result word.
    function automatic logic [OUT_W-1:0] sel_byte(input logic [DATA_W-1:0] word,
                                                  input logic              hi);
        return hi ? word[DATA_W-1:OUT_W] : word[OUT_W-1:0];
    endfunction

    assign in_ready  = (state_r != ST_DRAIN);
    assign accept_s  = in_valid & in_ready & ~clear;
    assign rd_edge_s = sync2_r & ~sync3_r;

    assign out_byte  = out_byte_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign done      = done_r;
    assign frame_err = frame_err_r;

    // rd_req two-flop synchronizer plus history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= rd_req;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Frame buffer; contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= in_data;
        end
    end

    // State, pointer and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            frame_err_r <= 1'b0;
            out_byte_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            frame_err_r <= frame_err_s;
            out_byte_r  <= out_byte_s;
            out_valid_r <= out_valid_s;
            out_last_r  <= out_last_s;
            done_r      <= done_s;
        end
    end

    // Next-state, pointer and buffer-write decode; clear overrides everything.
    always_comb begin
        state_s     = state_r;
        wr_ptr_s    = wr_ptr_r;
        rd_ptr_s    = rd_ptr_r;
        frame_err_s = frame_err_r;
        wr_en_s     = 1'b0;
        wr_addr_s   = (state_r == ST_FILL) ? wr_ptr_r : '0;
        if (clear) begin
            state_s     = ST_IDLE;
            wr_ptr_s    = '0;
            rd_ptr_s    = '0;
            frame_err_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        wr_en_s  = 1'b1;
                        rd_ptr_s = '0;
                        // A one-word "frame" is a framing error like any short frame.
                        if (in_last) begin
                            frame_err_s = 1'b1;
                            state_s     = ST_IDLE;
                            wr_ptr_s    = '0;
                        end else begin
                            state_s  = ST_FILL;
                            wr_ptr_s = WR_W'(1);
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_FILL: begin
                    if (accept_s) begin
                        wr_en_s = 1'b1;
                        if (wr_ptr_r == WR_LAST) begin
                            // Final slot: drain even if in_last is missing.
                            state_s  = ST_DRAIN;
                            rd_ptr_s = '0;
                            if (!in_last) begin
                                frame_err_s = 1'b1;
                            end else begin
                                frame_err_s = frame_err_r;
                            end
                        end else if (in_last) begin
                            frame_err_s = 1'b1;
                            state_s     = ST_IDLE;
                            wr_ptr_s    = '0;
                        end else begin
                            wr_ptr_s = wr_ptr_r + WR_W'(1);
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_DRAIN: begin
                    if (rd_edge_s) begin
                        if (rd_ptr_r == RD_LAST) begin
                            state_s = ST_DONE;
                        end else begin
                            rd_ptr_s = rd_ptr_r + RD_W'(1);
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    wr_ptr_s = '0;
                    rd_ptr_s = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the outputs register with it.
    always_comb begin
        out_byte_s  = '0;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        done_s      = 1'b0;
        case (state_s)
            ST_IDLE, ST_FILL: begin
                out_byte_s = '0;
            end
            ST_DRAIN: begin
                out_byte_s  = sel_byte(mem_r[rd_ptr_s[RD_W-1:1]], rd_ptr_s[0]);
                out_valid_s = 1'b1;
                out_last_s  = (rd_ptr_s == RD_LAST);
            end
            ST_DONE: begin
                out_byte_s = {OUT_W{1'b1}};
                done_s     = 1'b1;
            end
            default: begin
                out_byte_s = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_result_streamer.sv
module tb_matmul_result_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        rd_req;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_last;
    logic        done;
    logic        frame_err;

    int nvec = 0;
    int nmis = 0;

    // Reference frame: byte i of the stream is the low (even i) or high (odd i)
    // half of word i/2.
    logic [15:0] ref_w [9];

    matmul_result_streamer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .rd_req(rd_req), .out_byte(out_byte), .out_valid(out_valid),
        .out_last(out_last), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_byte(input int i);
        logic [15:0] w;
        w = ref_w[i / 2];
        return (i % 2 == 1) ? w[15:8] : w[7:0];
    endfunction

    task automatic rand_frame();
        for (int i = 0; i < 9; i++) ref_w[i] = 16'($urandom);
    endtask

    // Presents one word; waits (bounded) for in_ready.
    task automatic send_word(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            nvec++; nmis++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 9; i++) send_word(ref_w[i], (i == 8));
    endtask

    // rd_req high for 2 cycles, low for 2 cycles.
    task automatic rd_pulse();
        @(negedge clk);
        rd_req = 1'b1;
        repeat (2) @(negedge clk);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        in_last = 1'b0; rd_req = 1'b0;
        repeat (3) @(negedge clk);
        nvec++; if (in_ready !== 1'b1)   begin nmis++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        nvec++; if (out_byte !== 8'h00)  begin nmis++; $display("FAIL reset_out_byte: got %h want 00", out_byte); end
        nvec++; if (out_valid !== 1'b0)  begin nmis++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        nvec++; if (out_last !== 1'b0)   begin nmis++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        nvec++; if (done !== 1'b0)       begin nmis++; $display("FAIL reset_done: got %b want 0", done); end
        nvec++; if (frame_err !== 1'b0)  begin nmis++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 9; i++) ref_w[i] = 16'(i + 1);
        send_frame();
        for (int i = 0; i < 18; i++) begin
            nvec++; if (out_valid !== 1'b1) begin nmis++; $display("FAIL basic_valid[%0d]: got %b want 1", i, out_valid); end
            nvec++; if (out_byte !== exp_byte(i)) begin nmis++; $display("FAIL basic_byte[%0d]: got %h want %h", i, out_byte, exp_byte(i)); end
            nvec++; if (out_last !== (i == 17)) begin nmis++; $display("FAIL basic_last[%0d]: got %b want %b", i, out_last, (i == 17)); end
            rd_pulse();
        end
        nvec++; if (done !== 1'b1)      begin nmis++; $display("FAIL basic_done: got %b want 1", done); end
        nvec++; if (out_byte !== 8'hFF) begin nmis++; $display("FAIL basic_done_byte: got %h want ff", out_byte); end
        nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL basic_done_valid: got %b want 0", out_valid); end
        nvec++; if (out_last !== 1'b0)  begin nmis++; $display("FAIL basic_done_last: got %b want 0", out_last); end
        nvec++; if (in_ready !== 1'b1)  begin nmis++; $display("FAIL basic_done_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_full_range();
        for (int i = 0; i < 9; i++) ref_w[i] = ($urandom_range(0, 1) == 1) ? 16'hABCD : 16'hFFFF;
        ref_w[0] = 16'hABCD; ref_w[8] = 16'hFFFF;
        send_frame();
        for (int i = 0; i < 18; i++) begin
            nvec++; if (out_byte !== exp_byte(i)) begin nmis++; $display("FAIL range_byte[%0d]: got %h want %h", i, out_byte, exp_byte(i)); end
            rd_pulse();
        end
        nvec++; if (done !== 1'b1) begin nmis++; $display("FAIL range_done: got %b want 1", done); end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_word(ref_w[0], 1'b0);
            nvec++; if (done !== 1'b0) begin nmis++; $display("FAIL b2b_done_drop[%0d]: got %b want 0", f, done); end
            for (int i = 1; i < 9; i++) send_word(ref_w[i], (i == 8));
            for (int i = 0; i < 18; i++) begin
                nvec++; if (out_byte !== exp_byte(i) || out_valid !== 1'b1) begin
                    nmis++; $display("FAIL b2b_byte[%0d][%0d]: got %h/%b want %h/1", f, i, out_byte, out_valid, exp_byte(i));
                end
                rd_pulse();
            end
            nvec++; if (done !== 1'b1) begin nmis++; $display("FAIL b2b_done[%0d]: got %b want 1", f, done); end
        end
    endtask

    task automatic test_latency();
        rand_frame();
        send_frame();
        rd_req = 1'b1;                 // first sampled high at the next posedge (k)
        @(negedge clk);                // after edge k
        nvec++; if (out_byte !== exp_byte(0)) begin nmis++; $display("FAIL lat_k: got %h want %h", out_byte, exp_byte(0)); end
        @(negedge clk);                // after edge k+1
        nvec++; if (out_byte !== exp_byte(0)) begin nmis++; $display("FAIL lat_k1: got %h want %h", out_byte, exp_byte(0)); end
        rd_req = 1'b0;
        @(negedge clk);                // after edge k+2
        nvec++; if (out_byte !== exp_byte(1)) begin nmis++; $display("FAIL lat_k2: got %h want %h", out_byte, exp_byte(1)); end
        repeat (4) @(negedge clk);
        nvec++; if (out_byte !== exp_byte(1)) begin nmis++; $display("FAIL lat_single_edge: got %h want %h", out_byte, exp_byte(1)); end
        do_clear();
    endtask

    task automatic test_framing();
        rand_frame();
        for (int i = 0; i < 5; i++) send_word(ref_w[i], (i == 4));
        nvec++; if (frame_err !== 1'b1) begin nmis++; $display("FAIL frm_err: got %b want 1", frame_err); end
        nvec++; if (out_valid !== 1'b0) begin nmis++; $display("FAIL frm_valid: got %b want 0", out_valid); end
        nvec++; if (in_ready !== 1'b1 || out_byte !== 8'h00) begin nmis++; $display("FAIL frm_idle: got %b/%h want 1/00", in_ready, out_byte); end
        rand_frame();
        send_frame();
        for (int i = 0; i < 18; i++) begin
            nvec++; if (out_byte !== exp_byte(i) || out_valid !== 1'b1) begin
                nmis++; $display("FAIL frm_good_byte[%0d]: got %h/%b want %h/1", i, out_byte, out_valid, exp_byte(i));
            end
            rd_pulse();
        end
        nvec++; if (frame_err !== 1'b1) begin nmis++; $display("FAIL frm_sticky: got %b want 1", frame_err); end
        do_clear();
        nvec++; if (frame_err !== 1'b0) begin nmis++; $display("FAIL frm_cleared: got %b want 0", frame_err); end
        // Nine words without in_last: flagged but still drained.
        rand_frame();
        for (int i = 0; i < 9; i++) send_word(ref_w[i], 1'b0);
        nvec++; if (frame_err !== 1'b1) begin nmis++; $display("FAIL frm_nolast_err: got %b want 1", frame_err); end
        nvec++; if (out_valid !== 1'b1 || out_byte !== exp_byte(0)) begin
            nmis++; $display("FAIL frm_nolast_drain: got %b/%h want 1/%h", out_valid, out_byte, exp_byte(0));
        end
        do_clear();
    endtask

    task automatic test_backpressure();
        rand_frame();
        for (int i = 0; i < 4; i++) send_word(ref_w[i], 1'b0);
        rd_pulse();
        rd_pulse();
        for (int i = 4; i < 9; i++) send_word(ref_w[i], (i == 8));
        nvec++; if (in_ready !== 1'b0) begin nmis++; $display("FAIL bp_ready: got %b want 0", in_ready); end
        in_valid = 1'b1; in_data = 16'($urandom); in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 18; i++) begin
            nvec++; if (out_byte !== exp_byte(i) || out_valid !== 1'b1) begin
                nmis++; $display("FAIL bp_byte[%0d]: got %h/%b want %h/1", i, out_byte, out_valid, exp_byte(i));
            end
            rd_pulse();
        end
        nvec++; if (done !== 1'b1 || frame_err !== 1'b0) begin nmis++; $display("FAIL bp_done: got %b/%b want 1/0", done, frame_err); end
    endtask

    task automatic test_abort();
        rand_frame();
        send_frame();
        for (int i = 0; i < 7; i++) rd_pulse();
        nvec++; if (out_byte !== exp_byte(7)) begin nmis++; $display("FAIL abort_byte7: got %h want %h", out_byte, exp_byte(7)); end
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'($urandom); in_last = 1'b0;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b0 || out_byte !== 8'h00) begin nmis++; $display("FAIL abort_clear_out: got %b/%h want 0/00", out_valid, out_byte); end
        nvec++; if (in_ready !== 1'b1 || done !== 1'b0) begin nmis++; $display("FAIL abort_clear_state: got %b/%b want 1/0", in_ready, done); end
        rand_frame();
        send_frame();
        for (int i = 0; i < 18; i++) begin
            nvec++; if (out_byte !== exp_byte(i)) begin nmis++; $display("FAIL abort_next_byte[%0d]: got %h want %h", i, out_byte, exp_byte(i)); end
            rd_pulse();
        end
        // Reset partway through filling.
        rand_frame();
        for (int i = 0; i < 4; i++) send_word(ref_w[i], 1'b0);
        rst_n = 1'b0;
        #1;
        nvec++; if (out_valid !== 1'b0 || out_byte !== 8'h00 || done !== 1'b0 || in_ready !== 1'b1) begin
            nmis++; $display("FAIL abort_rst: got v%b b%h d%b r%b want v0 b00 d0 r1", out_valid, out_byte, done, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rand_frame();
        send_frame();
        for (int i = 0; i < 18; i++) begin
            nvec++; if (out_byte !== exp_byte(i) || out_last !== (i == 17)) begin
                nmis++; $display("FAIL abort_rst_byte[%0d]: got %h/%b want %h/%b", i, out_byte, out_last, exp_byte(i), (i == 17));
            end
            rd_pulse();
        end
        nvec++; if (done !== 1'b1) begin nmis++; $display("FAIL abort_rst_done: got %b want 1", done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_range();
        test_back_to_back();
        test_latency();
        test_framing();
        test_backpressure();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
